// File: rtl/biriscv_mul_issue_ctrl_pkg.sv
// Shared definitions for the multiplier issue controller: RV32M opcode patterns,
// request/tag records and the multiplier latency legality check.
package biriscv_mul_issue_ctrl_pkg;

  localparam logic [31:0] INST_MUL      = 32'h0200_0033;
  localparam logic [31:0] INST_MULH     = 32'h0200_1033;
  localparam logic [31:0] INST_MULHSU   = 32'h0200_2033;
  localparam logic [31:0] INST_MULHU    = 32'h0200_3033;
  localparam logic [31:0] INST_MUL_MASK = 32'hfe00_707f;

  // One in-flight multiply as tracked alongside the multiplier pipeline.
  typedef struct packed {
    logic       valid;
    logic       slot;
    logic [4:0] rd;
  } mul_tag_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] opcode;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0]  rd;
  } mul_req_t;

  function automatic bit mult_stages_legal(input int n);
    return (n == 2) || (n == 3);
  endfunction

endpackage

// File: rtl/biriscv_mul_issue_ctrl_if.sv
// Request, multiplier and writeback bundle between the issue slots, the shared
// multiplier and the issue controller.
interface biriscv_mul_issue_ctrl_if;

  logic        req0_valid;
  logic [31:0] req0_opcode;
  logic [31:0] req0_ra_operand;
  logic [31:0] req0_rb_operand;
  logic [4:0]  req0_rd_idx;
  logic        req0_ready;

  logic        req1_valid;
  logic [31:0] req1_opcode;
  logic [31:0] req1_ra_operand;
  logic [31:0] req1_rb_operand;
  logic [4:0]  req1_rd_idx;
  logic        req1_ready;

  logic        mul_valid;
  logic [31:0] mul_opcode;
  logic [31:0] mul_ra_operand;
  logic [31:0] mul_rb_operand;
  logic [31:0] mul_result;

  logic        wb_valid;
  logic        wb_slot;
  logic [4:0]  wb_rd_idx;
  logic [31:0] wb_value;
  logic [31:0] busy;

  // Core side: issue slots plus the multiplier's result return.
  modport master (
    output req0_valid, req0_opcode, req0_ra_operand, req0_rb_operand, req0_rd_idx,
    output req1_valid, req1_opcode, req1_ra_operand, req1_rb_operand, req1_rd_idx,
    output mul_result,
    input  req0_ready, req1_ready,
    input  mul_valid, mul_opcode, mul_ra_operand, mul_rb_operand,
    input  wb_valid, wb_slot, wb_rd_idx, wb_value, busy
  );

  modport slave (
    input  req0_valid, req0_opcode, req0_ra_operand, req0_rb_operand, req0_rd_idx,
    input  req1_valid, req1_opcode, req1_ra_operand, req1_rb_operand, req1_rd_idx,
    input  mul_result,
    output req0_ready, req1_ready,
    output mul_valid, mul_opcode, mul_ra_operand, mul_rb_operand,
    output wb_valid, wb_slot, wb_rd_idx, wb_value, busy
  );

endinterface

// File: rtl/biriscv_mul_tag_pipe.sv
// Shift register of in-flight multiply tags, moving in lockstep with the
// multiplier: frozen by hold, valids squashed by flush.
module biriscv_mul_tag_pipe
  import biriscv_mul_issue_ctrl_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     hold_i,
  input  logic     flush_i,
  input  mul_tag_t tag_i,
  output mul_tag_t tail_o
);

  mul_tag_t stage_q [STAGES];

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its predecessor's pre-edge value and the shift is order-independent.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < STAGES; i++) stage_q[i].valid <= 1'b0;
    end else if (!hold_i) begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tail_o = stage_q[STAGES-1];

endmodule

// File: rtl/biriscv_mul_issue_ctrl.sv
// Round-robin issue of slot 0/1 multiplies onto the shared pipelined multiplier,
// with tag tracking for writeback and a per-rd in-flight scoreboard.
module biriscv_mul_issue_ctrl
  import biriscv_mul_issue_ctrl_pkg::*;
#(
  parameter int MULT_STAGES = 2
) (
  input logic                      clk_i,
  input logic                      rst_i,
  input logic                      hold_i,
  input logic                      flush_i,
  biriscv_mul_issue_ctrl_if.slave  bus
);

  if (!mult_stages_legal(MULT_STAGES)) begin : g_stages_check
    $error("biriscv_mul_issue_ctrl: MULT_STAGES must be 2 or 3");
  end

  mul_req_t    req [2];
  logic [1:0]  elig;
  logic [1:0]  grant;
  logic        sel;
  logic        last_grant_q;
  logic [31:0] busy_q;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  mul_tag_t    tag_d;
  mul_tag_t    tail;
  logic        wb_valid;

  always_comb begin
    req[0] = '{valid: bus.req0_valid, opcode: bus.req0_opcode, ra: bus.req0_ra_operand,
               rb: bus.req0_rb_operand, rd: bus.req0_rd_idx};
    req[1] = '{valid: bus.req1_valid, opcode: bus.req1_opcode, ra: bus.req1_ra_operand,
               rb: bus.req1_rb_operand, rd: bus.req1_rd_idx};
  end

  // x0 never sets a busy bit, so it is always rd-eligible.
  always_comb begin
    // NOTE: every signal written here is fully assigned on all paths (loop plus
    // case default), so no latch can be inferred.
    for (int k = 0; k < 2; k++) begin
      elig[k] = req[k].valid & ((req[k].rd == 5'd0) | ~busy_q[req[k].rd]) & ~hold_i & ~flush_i;
    end
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Without a grant the mux falls back to slot 0 so the multiplier sees no X.
  assign sel = grant[1];

  assign bus.req0_ready     = grant[0];
  assign bus.req1_ready     = grant[1];
  assign bus.mul_valid      = |grant;
  assign bus.mul_opcode     = req[sel].opcode;
  assign bus.mul_ra_operand = req[sel].ra;
  assign bus.mul_rb_operand = req[sel].rb;

  assign tag_d = '{valid: |grant, slot: sel, rd: req[sel].rd};

  biriscv_mul_tag_pipe #(
    .STAGES (MULT_STAGES)
  ) u_tag_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .hold_i  (hold_i),
    .flush_i (flush_i),
    .tag_i   (tag_d),
    .tail_o  (tail)
  );

  assign wb_valid = tail.valid & ~hold_i;

  assign bus.wb_valid  = wb_valid;
  assign bus.wb_slot   = tail.slot;
  assign bus.wb_rd_idx = tail.rd;
  assign bus.wb_value  = bus.mul_result;

  // A busy rd is never granted, so the set and clear masks cannot overlap.
  assign set_mask = ((|grant) && (req[sel].rd != 5'd0)) ? (32'd1 << req[sel].rd) : 32'd0;
  assign clr_mask = wb_valid ? (32'd1 << tail.rd) : 32'd0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q       <= '0;
      last_grant_q <= 1'b1;
    end else begin
      if (flush_i) busy_q <= '0;
      else         busy_q <= (busy_q & ~clr_mask) | set_mask;
      if (|grant) last_grant_q <= sel;
    end
  end

  assign bus.busy = busy_q;

endmodule

// File: tb/tb_biriscv_mul_issue_ctrl.sv
// Self-checking bench: arbitration vector table, hand-written latency/hold/flush/
// reset sequences, and random traffic against an in-flight-list reference model.
module tb_biriscv_mul_issue_ctrl;
  import biriscv_mul_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst, hold, flush;
  always #5 clk = ~clk;

  biriscv_mul_issue_ctrl_if bus2 ();
  biriscv_mul_issue_ctrl_if bus3 ();

  biriscv_mul_issue_ctrl #(.MULT_STAGES(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush), .bus(bus2.slave));
  biriscv_mul_issue_ctrl #(.MULT_STAGES(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush), .bus(bus3.slave));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RV32M arithmetic; low 64 bits of a product of extended operands are exact.
  function automatic logic [31:0] mulcalc(input logic [31:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = (op[13:12] == 2'b11) ? {32'b0, a} : {{32{a[31]}}, a};
    xb = op[13] ? {32'b0, b} : {{32{b[31]}}, b};
    p  = xa * xb;
    return (op[14:12] == 3'b000) ? p[31:0] : p[63:32];
  endfunction

  // External pipelined multiplier models, stalled by the shared hold.
  logic [31:0] p2 [2];
  logic [31:0] p3 [3];
  always @(posedge clk) begin
    if (!hold) begin
      p2[0] <= mulcalc(bus2.mul_opcode, bus2.mul_ra_operand, bus2.mul_rb_operand);
      p2[1] <= p2[0];
      p3[0] <= mulcalc(bus3.mul_opcode, bus3.mul_ra_operand, bus3.mul_rb_operand);
      p3[1] <= p3[0];
      p3[2] <= p3[1];
    end
  end
  assign bus2.mul_result = p2[1];
  assign bus3.mul_result = p3[2];

  logic        v   [2];
  logic [31:0] opc [2];
  logic [31:0] ra  [2];
  logic [31:0] rb  [2];
  logic [4:0]  rd  [2];

  task automatic apply();
    bus2.req0_valid = v[0]; bus2.req0_opcode = opc[0]; bus2.req0_ra_operand = ra[0];
    bus2.req0_rb_operand = rb[0]; bus2.req0_rd_idx = rd[0];
    bus2.req1_valid = v[1]; bus2.req1_opcode = opc[1]; bus2.req1_ra_operand = ra[1];
    bus2.req1_rb_operand = rb[1]; bus2.req1_rd_idx = rd[1];
    bus3.req0_valid = v[0]; bus3.req0_opcode = opc[0]; bus3.req0_ra_operand = ra[0];
    bus3.req0_rb_operand = rb[0]; bus3.req0_rd_idx = rd[0];
    bus3.req1_valid = v[1]; bus3.req1_opcode = opc[1]; bus3.req1_ra_operand = ra[1];
    bus3.req1_rb_operand = rb[1]; bus3.req1_rd_idx = rd[1];
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      v[k] = 1'b0; opc[k] = INST_MUL; ra[k] = '0; rb[k] = '0; rd[k] = '0;
    end
    hold = 1'b0; flush = 1'b0; rst = 1'b0;
  endtask

  task automatic set_req(input int k, input logic [31:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] d);
    v[k] = 1'b1; opc[k] = o; ra[k] = a; rb[k] = b; rd[k] = d;
  endtask

  task automatic drive(); apply(); @(negedge clk); endtask
  task automatic adv();   @(posedge clk); #1;      endtask

  task automatic do_reset();
    idle(); rst = 1'b1; drive(); adv(); rst = 1'b0;
  endtask

  // Reference model: a list of in-flight ops with age = unheld cycles since grant.
  logic        mv    [2][4];
  logic        ms    [2][4];
  logic [4:0]  mr    [2][4];
  logic [31:0] mval  [2][4];
  int          mage  [2][4];
  logic        mlast [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) mv[m][i] = 1'b0;
      mlast[m] = 1'b1;
    end
  endtask

  task automatic model_cycle(input int m, input int s, input logic r0, input logic r1,
                             input logic wbv, input logic wslot, input logic [4:0] wrd,
                             input logic [31:0] wval, input logic [31:0] busy);
    logic [31:0] eb;
    logic [1:0]  el, g;
    int          wi, gk;
    eb = '0; wi = -1;
    for (int i = 0; i < 4; i++) begin
      if (mv[m][i]) begin
        if (mr[m][i] != 5'd0) eb[mr[m][i]] = 1'b1;
        if (mage[m][i] == s && !hold) wi = i;
      end
    end
    for (int k = 0; k < 2; k++) el[k] = v[k] && (rd[k] == 5'd0 || !eb[rd[k]]) && !hold && !flush;
    if (el == 2'b11) g = (mlast[m] == 1'b1) ? 2'b01 : 2'b10;
    else             g = el;
    check($sformatf("rand%0d busy", s), busy, eb);
    check($sformatf("rand%0d ready", s), {r1, r0}, g);
    check($sformatf("rand%0d wb_valid", s), wbv, wi >= 0);
    if (wi >= 0)
      check($sformatf("rand%0d wb_fields", s), {wslot, wrd, wval}, {ms[m][wi], mr[m][wi], mval[m][wi]});
    if (rst) begin
      for (int i = 0; i < 4; i++) mv[m][i] = 1'b0;
      mlast[m] = 1'b1;
    end else if (flush) begin
      for (int i = 0; i < 4; i++) mv[m][i] = 1'b0;
    end else if (!hold) begin
      if (wi >= 0) mv[m][wi] = 1'b0;
      for (int i = 0; i < 4; i++) if (mv[m][i]) mage[m][i]++;
      if (g != 2'b00) begin
        gk = g[1] ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
          if (!mv[m][i]) begin
            mv[m][i] = 1'b1; ms[m][i] = g[1]; mr[m][i] = rd[gk]; mage[m][i] = 1;
            mval[m][i] = mulcalc(opc[gk], ra[gk], rb[gk]);
            break;
          end
        end
        mlast[m] = g[1];
      end
    end
  endtask

  typedef struct {
    logic        v0, v1;
    logic [4:0]  rd0, rd1;
    logic        hold, flush;
    logic [1:0]  exp_ready;   // {ready1, ready0}
    logic [31:0] exp_busy;    // scoreboard one cycle later
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 5'd5, 5'd0,  1'b0, 1'b0, 2'b01, 32'h0000_0020};
    tbl[1] = '{1'b0, 1'b1, 5'd0, 5'd7,  1'b0, 1'b0, 2'b10, 32'h0000_0080};
    tbl[2] = '{1'b1, 1'b1, 5'd3, 5'd4,  1'b0, 1'b0, 2'b01, 32'h0000_0008};
    tbl[3] = '{1'b1, 1'b1, 5'd3, 5'd4,  1'b1, 1'b0, 2'b00, 32'h0000_0000};
    tbl[4] = '{1'b1, 1'b1, 5'd3, 5'd4,  1'b0, 1'b1, 2'b00, 32'h0000_0000};
    tbl[5] = '{1'b1, 1'b0, 5'd0, 5'd0,  1'b0, 1'b0, 2'b01, 32'h0000_0000};
    tbl[6] = '{1'b0, 1'b0, 5'd1, 5'd2,  1'b0, 1'b0, 2'b00, 32'h0000_0000};
    tbl[7] = '{1'b0, 1'b1, 5'd0, 5'd31, 1'b0, 1'b0, 2'b10, 32'h8000_0000};

    idle(); apply();

    // Reset state
    do_reset(); idle(); drive();
    check("rst busy2", bus2.busy, 32'h0);
    check("rst wb2", {bus2.wb_valid, bus2.wb_slot, bus2.wb_rd_idx}, 7'h0);
    check("rst ready2", {bus2.req1_ready, bus2.req0_ready, bus2.mul_valid}, 3'b000);
    check("rst wb3", {bus3.wb_valid, bus3.wb_slot, bus3.wb_rd_idx, bus3.busy}, 39'h0);

    // Single-cycle arbitration vectors, each from a fresh reset
    for (int i = 0; i < 8; i++) begin
      do_reset(); idle();
      v[0] = tbl[i].v0; v[1] = tbl[i].v1; rd[0] = tbl[i].rd0; rd[1] = tbl[i].rd1;
      hold = tbl[i].hold; flush = tbl[i].flush;
      drive();
      check($sformatf("vec%0d ready", i), {bus2.req1_ready, bus2.req0_ready}, tbl[i].exp_ready);
      check($sformatf("vec%0d mul_valid", i), bus2.mul_valid, |tbl[i].exp_ready);
      adv(); idle(); drive();
      check($sformatf("vec%0d busy", i), bus2.busy, tbl[i].exp_busy);
    end

    // Single issue: 7*6 -> x5, latency 2 and 3
    do_reset(); idle(); set_req(0, INST_MUL, 32'd7, 32'd6, 5'd5); drive();
    check("si ready", {bus2.req0_ready, bus3.req0_ready, bus2.mul_valid}, 3'b111);
    check("si mul_ops", {bus2.mul_ra_operand, bus2.mul_rb_operand}, {32'd7, 32'd6});
    adv(); idle(); drive();
    check("si t1", {bus2.wb_valid, bus2.busy[5]}, 2'b01);
    adv(); drive();
    check("si t2 wb2", {bus2.wb_valid, bus2.wb_slot, bus2.wb_rd_idx, bus2.wb_value, bus2.busy[5]},
          {1'b1, 1'b0, 5'd5, 32'd42, 1'b1});
    check("si t2 wb3", bus3.wb_valid, 1'b0);
    adv(); drive();
    check("si t3 wb3", {bus3.wb_valid, bus3.wb_rd_idx, bus3.wb_value}, {1'b1, 5'd5, 32'd42});
    check("si t3 dut2", {bus2.wb_valid, bus2.busy[5]}, 2'b00);

    // Contention and round-robin alternation
    do_reset(); idle();
    set_req(0, INST_MUL, 32'd3, 32'd4, 5'd3); set_req(1, INST_MUL, 32'd5, 32'd6, 5'd4); drive();
    check("rr c0", {bus2.req1_ready, bus2.req0_ready}, 2'b01);
    adv(); set_req(0, INST_MUL, 32'd1, 32'd1, 5'd5); drive();
    check("rr c1", {bus2.req1_ready, bus2.req0_ready}, 2'b10);
    adv(); set_req(0, INST_MUL, 32'd10, 32'd10, 5'd6); set_req(1, INST_MUL, 32'd2, 32'd2, 5'd8); drive();
    check("rr c2", {bus2.req1_ready, bus2.req0_ready}, 2'b01);
    check("rr wb0", {bus2.wb_valid, bus2.wb_slot, bus2.wb_rd_idx, bus2.wb_value}, {1'b1, 1'b0, 5'd3, 32'd12});
    adv(); idle(); drive();
    check("rr wb1", {bus2.wb_valid, bus2.wb_slot, bus2.wb_rd_idx, bus2.wb_value}, {1'b1, 1'b1, 5'd4, 32'd30});
    adv(); drive();
    check("rr wb2", {bus2.wb_valid, bus2.wb_slot, bus2.wb_rd_idx, bus2.wb_value}, {1'b1, 1'b0, 5'd6, 32'd100});

    // WAW on x9: same-rd request waits for the writeback edge
    do_reset(); idle(); set_req(1, INST_MULH, 32'hFFFF_FFFE, 32'd3, 5'd9); drive();
    check("waw t0", bus2.req1_ready, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      adv(); idle(); set_req(0, INST_MUL, 32'd2, 32'd2, 5'd9); drive();
      check($sformatf("waw t%0d ready0", c), bus2.req0_ready, c == 3);
      check($sformatf("waw t%0d busy9", c), bus2.busy[9], c != 3);
      if (c == 2)
        check("waw wb", {bus2.wb_valid, bus2.wb_slot, bus2.wb_value}, {1'b1, 1'b1, 32'hFFFF_FFFF});
    end

    // Hold for three cycles after the grant: one pulse at T+5
    do_reset(); idle(); set_req(0, INST_MUL, 32'd9, 32'd9, 5'd12); drive();
    check("hold t0", bus2.req0_ready, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      adv(); idle(); hold = (c <= 3); drive();
      check($sformatf("hold t%0d wb", c), bus2.wb_valid, c == 5);
      if (c == 5) check("hold value", {bus2.wb_rd_idx, bus2.wb_value}, {5'd12, 32'd81});
    end

    // Flush, then reset, with two ops in flight and the tail under hold
    for (int mode = 0; mode < 2; mode++) begin
      do_reset(); idle(); set_req(0, INST_MUL, 32'd2, 32'd3, 5'd1); drive();
      adv(); idle(); set_req(1, INST_MUL, 32'd4, 32'd5, 5'd2); drive();
      adv(); idle(); set_req(0, INST_MUL, 32'd6, 32'd7, 5'd6); hold = 1'b1;
      if (mode == 0) flush = 1'b1; else rst = 1'b1;
      drive();
      check($sformatf("sq%0d busy before", mode), bus2.busy, 32'h0000_0006);
      check($sformatf("sq%0d cycle", mode), {bus2.req0_ready, bus2.wb_valid, bus3.wb_valid}, 3'b000);
      for (int c = 3; c <= 5; c++) begin
        adv(); idle(); drive();
        check($sformatf("sq%0d t%0d", mode, c),
              {bus2.wb_valid, bus3.wb_valid, bus2.busy, bus3.busy}, 66'h0);
      end
    end

    // Random traffic against the reference model, both latencies at once
    do_reset(); model_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 2; k++) begin
        v[k]   = ($urandom_range(0, 3) != 0);
        rd[k]  = 5'($urandom_range(0, 7));
        ra[k]  = $urandom;
        rb[k]  = $urandom;
        opc[k] = INST_MUL | (32'($urandom_range(0, 3)) << 12);
      end
      hold  = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 29) == 0);
      rst   = ($urandom_range(0, 59) == 0);
      drive();
      model_cycle(0, 2, bus2.req0_ready, bus2.req1_ready, bus2.wb_valid, bus2.wb_slot,
                  bus2.wb_rd_idx, bus2.wb_value, bus2.busy);
      model_cycle(1, 3, bus3.req0_ready, bus3.req1_ready, bus3.wb_valid, bus3.wb_slot,
                  bus3.wb_rd_idx, bus3.wb_value, bus3.busy);
      adv();
    end

    idle(); apply();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/biriscv_mul_issue_ctrl.md
# biriscv_mul_issue_ctrl

Arbitrates and sequences access to the single shared pipelined integer multiplier between the two issue slots of the dual-issue core. Accepts MUL/MULH/MULHSU/MULHU requests from slot 0 and slot 1 with a valid/ready handshake and grants at most one per cycle using round-robin. Drives the multiplier's operand and opcode inputs, tracks in-flight operations with a tag pipeline matched to multiplier latency, and returns each result with its destination register and originating slot. Maintains a destination scoreboard so that at most one operation per rd is in flight.

## Interface
Parameters:
- MULT_STAGES, 2, multiplier result latency in cycles (legal values 2 or 3); must match the multiplier instance.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- hold_i  in  1  pipeline hold; same signal as the multiplier's hold input
- flush_i  in  1  squash all in-flight operations
- req0_valid_i / req1_valid_i  in  1  slot request valid
- req0_opcode_i / req1_opcode_i  in  32  instruction word (already decoded as an M-extension multiply)
- req0_ra_operand_i / req1_ra_operand_i  in  32  rs1 value
- req0_rb_operand_i / req1_rb_operand_i  in  32  rs2 value
- req0_rd_idx_i / req1_rd_idx_i  in  5  destination register
- req0_ready_o / req1_ready_o  out  1  request accepted this cycle
- mul_valid_o  out  1  issue to multiplier (drives its opcode_valid_i)
- mul_opcode_o  out  32  granted opcode
- mul_ra_operand_o, mul_rb_operand_o  out  32  granted operands
- mul_result_i  in  32  multiplier writeback value
- wb_valid_o  out  1  result valid, one pulse per operation
- wb_slot_o  out  1  originating slot
- wb_rd_idx_o  out  5  destination register
- wb_value_o  out  32  result (passthrough of mul_result_i)
- busy_o  out  32  scoreboard: bit n set while an operation targeting xn is in flight

## Operation
- Eligibility, slot k: reqk_valid_i & ~busy_o[reqk_rd_idx_i] & ~hold_i & ~flush_i. A request with rd=x0 is always rd-eligible.
- Arbitration: with one slot eligible, grant it. With both eligible, grant the slot ≠ last_grant_q. last_grant_q updates on every grant. Its reset value is 1, so slot 0 wins the first contention.
- reqk_ready_o = grant_k. Combinational from same-cycle inputs. There is no valid→ready dependency loop beyond this.
- mul_valid_o = grant_0 | grant_1. mul_* fields come from the granted slot. When there is no grant, fields are don't-care but must be driven by slot 0 inputs, so no X propagates.
- Tag pipeline: MULT_STAGES entries of {valid, slot, rd}. Entry 0 loads the grant every non-held cycle. The pipeline shifts when ~hold_i and freezes when hold_i.
- Writeback: wb_valid_o = tail.valid & ~hold_i. wb_slot_o and wb_rd_idx_o come from the tail.
- Scoreboard: set bit rd on grant (rd≠0). Clear bit rd when wb_valid_o is high. Set and clear never collide, because a busy rd is ineligible.
- Flush: clears all tag valids and the whole scoreboard on the next edge. No grant occurs in the flush cycle. flush_i overrides hold_i for clearing.
- Reset: tag valids = 0, busy_o = 0, last_grant_q = 1. All outputs are therefore 0/deasserted the cycle after reset, except mul_* data.

## Timing
- Grant in cycle T (hold low throughout) → wb_valid_o in cycle T+MULT_STAGES, with wb_value_o correct in that cycle.
- Each hold cycle in the window adds one cycle of latency. A tail held under hold_i emits exactly one wb_valid_o pulse, after hold drops.
- Back-to-back grants every cycle are allowed (throughput 1/cycle) for distinct rd.
- A same-rd request is accepted no earlier than cycle T+MULT_STAGES+1. busy_o clears on the edge that ends the writeback cycle.
- Reset asserted mid-operation discards all in-flight tags. No wb_valid_o is produced for them.

## Structure
- Tag entry typedef and MULT_STAGES legality check belong in shared core defs alongside the RV32M opcode constants.
- One natural sub-module: biriscv_mul_tag_pipe, a parameterised shift register of tags with hold and flush.
- Arbiter, scoreboard and mux live in the top.

## Test plan
- Single issue: slot0 MUL rd=5, ra=7, rb=6, idle hold, MULT_STAGES=2 → ready0 in T; wb_valid_o at T+2 with rd=5, slot=0, value 42; busy_o[5] high T+1..T+2.
- Contention: both slots valid (rd 3, rd 4) for 2 cycles from reset → slot0 granted first, slot1 next; results in that order.
- WAW: slot1 MULH rd=9 issued, slot0 requests rd=9 next cycle → ready0 low until busy_o[9] clears; grant at T+3.
- Hold: grant at T, hold_i high at T+1 for 3 cycles → exactly one wb_valid_o pulse, at T+5.
- Flush/reset: two ops in flight, flush_i pulse (then, separately, rst_i) → no wb_valid_o; busy_o = 0; same-cycle request not granted.
- MULT_STAGES=3 rerun of the single-issue case → wb_valid_o at T+3.
